spi_master_engine: RTL and testbench

- Parametrised SPI master serial engine, the next generation of the single-byte, single-select SPI master IO.
- Adds a configurable frame width, multiple slave selects and full CPOL/CPHA mode support.
- Adds burst transfers that keep select asserted across frames, and a valid/ready TX handshake with a per-frame RX strobe.
- Sits between the SPI register/FIFO layer and the pads.

---
 rtl/spi_master_engine.sv | 210 +++++++++++++++++++++
 tb/tb_spi_master_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_engine.sv
// SPI master serial engine: DW-bit frames, NSS selects, CPOL/CPHA, bursts.
// Optional SPI_LOOPBACK_EN adds a loopback input routing mosi into rx.
module spi_master_engine #(
  parameter int DW  = 32,
  parameter int NSS = 4,
  parameter int CW  = 8,
  localparam int FW = $clog2(DW),
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           lsbfirst,
  input  logic [FW-1:0]  framesize,
  input  logic [CW-1:0]  clkdiv,
  input  logic [SW-1:0]  ss_sel,
  input  logic           manual_mode,
  input  logic [NSS-1:0] manual_ss,
  input  logic           tx_valid,
  input  logic [DW-1:0]  tx_data,
  output logic           tx_ready,
  output logic           rx_valid,
  output logic [DW-1:0]  rx_data,
  output logic           busy,
  output logic [2:0]     spi_state,
  output logic           sclk,
  output logic           mosi,
`ifdef SPI_LOOPBACK_EN
  input  logic           loopback,
`endif
  input  logic           miso,
  output logic [NSS-1:0] ss_n
);

  localparam int EW = FW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    DATA   = 3'd2,
    HOLD   = 3'd3,
    MARGIN = 3'd4
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [EW-1:0]  edge_cnt;
  logic [DW-1:0]  tx_buf;
  logic [DW-1:0]  rx_buf;
  logic [DW-1:0]  rx_nxt;
  logic [FW-1:0]  fs;
  logic           l_cpol;
  logic           l_cpha;
  logic           l_lsb;
  logic [SW-1:0]  l_sel;
  logic           sclk_r;
  logic           mosi_r;
  logic           rx_valid_r;
  logic [DW-1:0]  rx_data_r;
  logic [NSS-1:0] ss_r;
  logic           tick;
  logic           leading;
  logic           last_edge;
  logic           sample_now;
  logic           accept;
  logic           sin;
  logic [FW-1:0]  bit_k;

  assign tick       = (state != IDLE) && (cnt == clkdiv);
  assign bit_k      = edge_cnt[EW-1:1];
  assign leading    = ~edge_cnt[0];
  assign last_edge  = (edge_cnt == {fs, 1'b1});
  assign sample_now = (state == DATA) && tick && (leading != l_cpha);
  assign accept     = tx_valid &&
                      ((state == IDLE) ||
                       ((state == DATA) && tick && last_edge));

`ifdef SPI_LOOPBACK_EN
  assign sin  = loopback ? mosi_r : miso;
  assign mosi = mosi_r & ~loopback;
`else
  assign sin  = miso;
  assign mosi = mosi_r;
`endif

  assign tx_ready  = accept & nreset;
  assign rx_valid  = rx_valid_r;
  assign rx_data   = rx_data_r;
  assign busy      = (state != IDLE);
  assign spi_state = state;
  assign sclk      = sclk_r;
  assign ss_n      = ss_r;

  // Bit k of the frame on the wire maps to this data position.
  function automatic logic [FW-1:0] pos(input logic [FW-1:0] k);
    return l_lsb ? k : fs - k;
  endfunction

  function automatic logic [NSS-1:0] sel_ss(input logic [SW-1:0] s);
    logic [NSS-1:0] v;
    v = '1;
    for (int i = 0; i < NSS; i++)
      if (s == SW'(i)) v[i] = 1'b0;
    return v;
  endfunction

  always_comb begin
    rx_nxt = rx_buf;
    if (sample_now) rx_nxt[pos(bit_k)] = sin;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cnt        <= '0;
      edge_cnt   <= '0;
      tx_buf     <= '0;
      rx_buf     <= '0;
      fs         <= '0;
      l_cpol     <= 1'b0;
      l_cpha     <= 1'b0;
      l_lsb      <= 1'b0;
      l_sel      <= '0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
      ss_r       <= '1;
    end else begin
      rx_valid_r <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          sclk_r <= cpol;
          mosi_r <= 1'b0;
          ss_r   <= '1;
          if (tx_valid) begin
            tx_buf   <= tx_data;
            fs       <= framesize;
            l_cpol   <= cpol;
            l_cpha   <= cpha;
            l_lsb    <= lsbfirst;
            l_sel    <= ss_sel;
            rx_buf   <= '0;
            edge_cnt <= '0;
            mosi_r   <= ~cpha &
                        (lsbfirst ? tx_data[0] : tx_data[framesize]);
            ss_r     <= sel_ss(ss_sel);
            state    <= SETUP;
          end
        end
        SETUP: begin
          ss_r <= sel_ss(l_sel);
          if (tick) state <= DATA;
        end
        DATA: begin
          ss_r <= sel_ss(l_sel);
          if (tick) begin
            sclk_r   <= ~sclk_r;
            edge_cnt <= edge_cnt + EW'(1);
            rx_buf   <= rx_nxt;
            if (leading && l_cpha)
              mosi_r <= tx_buf[pos(bit_k)];
            if (!leading && !l_cpha && !last_edge)
              mosi_r <= tx_buf[pos(bit_k + FW'(1))];
            if (last_edge) begin
              rx_valid_r <= 1'b1;
              rx_data_r  <= rx_nxt;
              // Burst: next frame starts without releasing select.
              if (tx_valid) begin
                tx_buf   <= tx_data;
                fs       <= framesize;
                l_cpol   <= cpol;
                l_cpha   <= cpha;
                l_lsb    <= lsbfirst;
                rx_buf   <= '0;
                edge_cnt <= '0;
                sclk_r   <= cpol;
                if (!cpha)
                  mosi_r <= lsbfirst ? tx_data[0]
                                     : tx_data[framesize];
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          sclk_r <= l_cpol;
          ss_r   <= sel_ss(l_sel);
          if (tick) begin
            state  <= MARGIN;
            ss_r   <= '1;
            mosi_r <= 1'b0;
          end
        end
        MARGIN: begin
          sclk_r <= l_cpol;
          ss_r   <= '1;
          mosi_r <= 1'b0;
          if (tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (manual_mode) ss_r <= ~manual_ss;
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Randomised bench for spi_master_engine with a bit-stream SPI slave model.
// Checks rx/mosi streams, select timing, sclk edges, bursts, manual, reset.
module tb_spi_master_engine;

  localparam int DW  = 32;
  localparam int NSS = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsbfirst = 1'b0;
  logic [4:0]     framesize = '0;
  logic [CW-1:0]  clkdiv = '0;
  logic [1:0]     ss_sel = '0;
  logic           manual_mode = 1'b0;
  logic [NSS-1:0] manual_ss = '0;
  logic           tx_valid = 1'b0;
  logic [DW-1:0]  tx_data = '0;
  logic           tx_ready;
  logic           rx_valid;
  logic [DW-1:0]  rx_data;
  logic           busy;
  logic [2:0]     spi_state;
  logic           sclk;
  logic           mosi;
  logic           miso;
  logic [NSS-1:0] ss_n;

  always #5 clk = ~clk;

  spi_master_engine #(.DW(DW), .NSS(NSS), .CW(CW)) dut (
    .clk(clk), .nreset(nreset), .cpol(cpol), .cpha(cpha),
    .lsbfirst(lsbfirst), .framesize(framesize), .clkdiv(clkdiv),
    .ss_sel(ss_sel), .manual_mode(manual_mode), .manual_ss(manual_ss),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .spi_state(spi_state), .sclk(sclk), .mosi(mosi),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .miso(miso), .ss_n(ss_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: configuration the bench believes is in force.
  logic        t_cpol = 1'b0;
  logic        t_cpha = 1'b0;
  logic        t_lsb = 1'b0;
  logic        echo = 1'b1;
  int          t_n = 8;
  int          t_div = 0;
  int          t_sel = 0;
  logic [63:0] t_word = '0;
  int          sedge = 0;
  logic        cap[$];
  logic        sel_act;

  function automatic logic slave_bit(input int e, input logic ph,
                                     input logic lsb, input int n,
                                     input logic [63:0] w);
    int j;
    int b;
    j = ph ? (e + 1) / 2 - 1 : e / 2;
    if (j < 0) return 1'b0;
    b = j % n;
    return lsb ? w[b] : w[n - 1 - b];
  endfunction

  assign sel_act = ~&ss_n;
  assign miso = echo ? mosi
                     : slave_bit(sedge, t_cpha, t_lsb, t_n, t_word);

  always @(posedge sel_act) sedge = 0;

  always @(sclk) begin
    if (sel_act) begin
      sedge = sedge + 1;
      if ((sclk != t_cpol) != t_cpha) cap.push_back(mosi);
    end
  end

  // Cycle monitor
  int          cyc = 0;
  int          rx_cnt, rdy_cnt, rises, per_viol, mosi_viol;
  int          hold_cnt, man_viol, last_rise, exp_period;
  int          ss_low[NSS];
  logic [31:0] rxq[$];
  bit          man_on = 1'b0;
  logic [3:0]  man_exp = '0;
  logic        p_sclk = 1'b0;
  logic        p_mosi = 1'b0;
  logic [2:0]  p_state = '0;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      rx_cnt++;
      rxq.push_back(rx_data);
    end
    if (tx_ready) rdy_cnt++;
    for (int i = 0; i < NSS; i++)
      if (!ss_n[i]) ss_low[i]++;
    if (busy && sclk && !p_sclk) begin
      rises++;
      if (last_rise >= 0 && cyc - last_rise != exp_period) per_viol++;
      last_rise = cyc;
    end
    if (p_state == 3'd2 && spi_state == 3'd2 && mosi != p_mosi &&
        !(sclk != p_sclk && ((sclk != t_cpol) == t_cpha)))
      mosi_viol++;
    if (spi_state == 3'd3 && p_state != 3'd3) hold_cnt++;
    if (man_on && ss_n != man_exp) man_viol++;
    p_sclk  = sclk;
    p_mosi  = mosi;
    p_state = spi_state;
  end

  task automatic clr();
    rx_cnt = 0; rdy_cnt = 0; rises = 0; per_viol = 0;
    mosi_viol = 0; hold_cnt = 0; man_viol = 0; last_rise = -1;
    for (int i = 0; i < NSS; i++) ss_low[i] = 0;
    rxq.delete();
    cap.delete();
  endtask

  function automatic logic [63:0] frame_word(input int base);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < t_n; j++)
      if (base + j < cap.size())
        w[t_lsb ? j : t_n - 1 - j] = cap[base + j];
    return w;
  endfunction

  task automatic set_cfg(input int n, input int div, input bit pol,
                         input bit pha, input bit lsb, input int sel,
                         input logic [63:0] word, input bit ech);
    framesize = 5'(n - 1); clkdiv = CW'(div);
    cpol = pol; cpha = pha; lsbfirst = lsb; ss_sel = 2'(sel);
    t_n = n; t_div = div; t_cpol = pol; t_cpha = pha; t_lsb = lsb;
    t_sel = sel; t_word = word; echo = ech;
    exp_period = 2 * (div + 1);
    repeat (3) @(negedge clk);
    clr();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", k < 5000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic xfer(input logic [31:0] txw, input bit full);
    logic [63:0] mask;
    int others;
    mask = (64'd1 << t_n) - 64'd1;
    tx_valid = 1'b1;
    tx_data = txw;
    #1 check("tx_ready", tx_ready, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    tx_data = $urandom;
    wait_idle();
    check("rx_cnt", rx_cnt, 1);
    check("rdy_cnt", rdy_cnt, 1);
    if (rxq.size() > 0)
      check("rx_data", rxq[0], (echo ? {32'd0, txw} : t_word) & mask);
    check("rises", rises, t_n);
    check("sclk_period", per_viol, 0);
    check("mosi_edge", mosi_viol, 0);
    check("hold_once", hold_cnt, 1);
    if (full) begin
      check("cap_len", cap.size(), t_n);
      check("mosi_word", frame_word(0), {32'd0, txw} & mask);
      check("ss_low", ss_low[t_sel], (2 * t_n + 2) * (t_div + 1));
      others = 0;
      for (int i = 0; i < NSS; i++)
        if (i != t_sel) others += ss_low[i];
      check("ss_other", others, 0);
    end
  endtask

  task automatic burst3(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2);
    logic [31:0] w[3];
    logic [63:0] mask;
    int h;
    int k;
    w[0] = w0; w[1] = w1; w[2] = w2;
    h = t_div + 1;
    mask = (64'd1 << t_n) - 64'd1;
    tx_valid = 1'b1;
    tx_data = w[0];
    #1 check("b_ready0", tx_ready, 1);
    @(posedge clk);
    #1;
    for (int f = 1; f < 3; f++) begin
      tx_data = w[f];
      k = 0;
      while (!tx_ready && k < 3000) begin
        @(posedge clk);
        #1 k++;
      end
      check("burst_gap", k,
            (f == 1) ? h * (2 * t_n + 1) - 1 : 2 * t_n * h - 1);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    wait_idle();
    check("b_rx_cnt", rx_cnt, 3);
    check("b_rdy_cnt", rdy_cnt, 3);
    check("b_hold", hold_cnt, 1);
    check("b_rises", rises, 3 * t_n);
    check("b_period", per_viol, 0);
    check("b_mosi_edge", mosi_viol, 0);
    check("b_ss_low", ss_low[t_sel], h * (6 * t_n + 2));
    check("b_cap_len", cap.size(), 3 * t_n);
    for (int f = 0; f < 3; f++) begin
      if (rxq.size() > f)
        check("b_rx_data", rxq[f], {32'd0, w[f]} & mask);
      check("b_mosi_word", frame_word(f * t_n), {32'd0, w[f]} & mask);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    repeat (3) @(negedge clk);
    check("rst_ss_n", ss_n, 4'hF);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_state", spi_state, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    nreset = 1'b1;

    // 8-bit msb-first mode 0, looped back
    set_cfg(8, 1, 0, 0, 0, 0, 0, 1);
    xfer(32'hA5, 1);

    // All four modes, lsb first, slave answers 0xBEEF
    for (int m = 0; m < 4; m++) begin
      set_cfg(16, 1, m[1], m[0], 1, 1, 64'hBEEF, 0);
      xfer(32'h1234, 1);
    end

    // 1-bit frames at the fastest clock
    set_cfg(1, 0, 0, 0, 0, 3, 64'h1, 0);
    xfer(32'h0, 1);
    set_cfg(1, 0, 1, 1, 1, 2, 64'h0, 0);
    xfer(32'h1, 1);

    for (int i = 0; i < 12; i++) begin
      set_cfg($urandom_range(1, 32), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3),
              {32'd0, $urandom}, 1'($urandom_range(0, 1)));
      xfer($urandom, 1);
    end

    // Burst of three frames on select 2
    for (int m = 0; m < 2; m++) begin
      set_cfg(12, 1, 1'(m), 1'(m), 1'(m), 2, 0, 1);
      burst3($urandom, $urandom, $urandom);
    end

    // Manual select mode
    manual_mode = 1'b1;
    manual_ss = 4'b1001;
    man_exp = 4'b0110;
    set_cfg(8, 1, 0, 1, 0, 0, 0, 1);
    man_on = 1'b1;
    xfer($urandom, 0);
    check("man_viol", man_viol, 0);
    check("man_ss_n", ss_n, 4'b0110);
    man_on = 1'b0;
    manual_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("man_release", ss_n, 4'hF);

    // Reset mid-DATA aborts the frame
    set_cfg(16, 2, 1, 0, 0, 1, 0, 1);
    tx_valid = 1'b1;
    tx_data = $urandom;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 0; k < 200 && spi_state != 3'd2; k++)
      @(negedge clk);
    check("abort_in_data", spi_state, 2);
    repeat (10) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_ss_n", ss_n, 4'hF);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", mosi, 0);
    @(posedge clk);
    #1 check("abort_rx_valid", rx_valid, 0);
    @(negedge clk);
    check("abort_rx_cnt", rx_cnt, 0);
    nreset = 1'b1;
    set_cfg(16, 2, 1, 0, 0, 1, 0, 1);
    xfer($urandom, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
